// File: rtl/h_rom_loader.sv
// ---------------------------------------------------------------------------
// h_rom_loader
//
// Downloads a program for the hCPU into a local instruction memory and runs it.
// The CPU stays in reset while a frame is received. A frame is a 16-bit word
// count N, then N 16-bit words, then a 16-bit checksum. Every 16-bit field is
// sent high byte first. The checksum is the sum of the words modulo 2**16.
// If the checksum matches, the CPU is released and fetches from the memory.
// If it does not match, or N is too large, the loader goes to the error state.
//
// Parameters
//   ADDR_W       instruction memory address width (2**ADDR_W words of 16 bits)
//
// Ports
//   clock        single clock; all state changes happen on the rising edge
//   reset_n      asynchronous, active-low reset
//   load         one-cycle request to start a new download (IDLE/RUN/ERR only)
//   rx_data      download byte stream
//   rx_valid     rx_data holds a valid byte
//   rx_ready     a byte is accepted on a rising edge when rx_valid & rx_ready
//   pc           instruction address from the hCPU
//   instruction  instruction word to the hCPU (zero outside RUN)
//   cpu_reset    active-high hCPU reset (low only in RUN)
//   done         program loaded and verified; CPU running
//   error        download rejected
// ---------------------------------------------------------------------------
module h_rom_loader #(
  parameter int ADDR_W = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [15:0] pc,
  output logic [15:0] instruction,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  localparam int          DEPTH   = 1 << ADDR_W;
  // The depth needs 17 bits so that it can represent 2**16 when ADDR_W = 16.
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    SUM_HI,
    SUM_LO,
    RUN,
    ERR
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  hi_reg,    hi_next;     // high byte of the field in progress
  logic [15:0] len_reg,   len_next;    // word count N of the current frame
  logic [16:0] addr_reg,  addr_next;   // write address; 17 bits so addr+1 can reach N
  logic [15:0] sum_reg,   sum_next;    // running word sum modulo 2**16

  logic        mem_we;
  logic [15:0] rx_word;
  logic [15:0] rd_word;
  logic [16:0] addr_inc;

  // The memory is not reset. It keeps its contents across reset and across
  // downloads, except for the locations that a download writes.
  logic [15:0] mem [DEPTH];

  // The assembled 16-bit field: the captured high byte and the current byte.
  assign rx_word  = {hi_reg, rx_data};
  assign addr_inc = addr_reg + 17'd1;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      hi_reg    <= 8'h00;
      len_reg   <= 16'h0000;
      addr_reg  <= 17'd0;
      sum_reg   <= 16'h0000;
    end else begin
      state_reg <= state_next;
      hi_reg    <= hi_next;
      len_reg   <= len_next;
      addr_reg  <= addr_next;
      sum_reg   <= sum_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    hi_next    = hi_reg;
    len_next   = len_reg;
    addr_next  = addr_reg;
    sum_next   = sum_reg;
    mem_we     = 1'b0;
    rx_ready   = 1'b0;
    cpu_reset  = 1'b1;
    done       = 1'b0;
    error      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (load) begin
          state_next = LEN_HI;
        end
      end

      LEN_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          hi_next    = rx_data;
          state_next = LEN_LO;
        end
      end

      LEN_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          len_next  = rx_word;
          addr_next = 17'd0;
          sum_next  = 16'h0000;
          if ({1'b0, rx_word} > DEPTH_W) begin
            // The frame does not fit. Reject it before any word is written.
            state_next = ERR;
          end else if (rx_word == 16'h0000) begin
            // An empty program: only the checksum (zero) follows.
            state_next = SUM_HI;
          end else begin
            state_next = DATA_HI;
          end
        end
      end

      DATA_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          hi_next    = rx_data;
          state_next = DATA_LO;
        end
      end

      DATA_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          mem_we    = 1'b1;
          sum_next  = sum_reg + rx_word;
          addr_next = addr_inc;
          if (addr_inc == {1'b0, len_reg}) begin
            state_next = SUM_HI;
          end else begin
            state_next = DATA_HI;
          end
        end
      end

      SUM_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          hi_next    = rx_data;
          state_next = SUM_LO;
        end
      end

      SUM_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (rx_word == sum_reg) begin
            state_next = RUN;
          end else begin
            state_next = ERR;
          end
        end
      end

      RUN: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
        // Restarting reasserts cpu_reset from the next cycle. The CPU then
        // stays in reset for the whole transfer.
        if (load) begin
          state_next = LEN_HI;
        end
      end

      ERR: begin
        error = 1'b1;
        if (load) begin
          state_next = LEN_HI;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Instruction memory
  // ---------------------------------------------------------------------------
  // Write port. mem_we is only active in DATA_LO. An asserted reset_n forces the
  // state to IDLE at once, so a download cut off by reset writes nothing more.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[addr_reg[ADDR_W-1:0]] <= rx_word;
    end
  end

  // Read port. The read is asynchronous, so the hCPU sees the word in the same
  // cycle that it presents pc. The upper pc bits are dropped, so addresses
  // wrap around the memory.
  assign rd_word = mem[pc[ADDR_W-1:0]];

  always_comb begin
    instruction = 16'h0000;
    if (state_reg == RUN) begin
      instruction = rd_word;
    end
  end

  // The pc bits above the memory size do not take part in addressing.
  generate
    if (ADDR_W < 16) begin : g_pc_hi
      logic unused_pc_hi;
      assign unused_pc_hi = ^pc[15:ADDR_W];
    end
  endgenerate

endmodule

// File: doc/h_rom_loader.md
H_ROM_LOADER -- requirements
Module: h_rom_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, instruction-memory address width (depth 2**ADDR_W words of 16 bits).
REQ-002 SHALL have port clock  input  1  single clock, all state changes on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port load  input  1  one-cycle request to start a new program download.
REQ-005 SHALL have port rx_data  input  8  download byte stream.
REQ-006 SHALL have port rx_valid  input  1  rx_data holds a valid byte.
REQ-007 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have port pc  input  16  instruction address from the hCPU pc output.
REQ-009 SHALL have port instruction  output  16  instruction word to the hCPU instruction input.
REQ-010 SHALL have port cpu_reset  output  1  active-high reset to the hCPU reset input.
REQ-011 SHALL have port done  output  1  program loaded and verified; CPU running.
REQ-012 SHALL have port error  output  1  download rejected.

Function
REQ-013 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, SUM_HI, SUM_LO, RUN, ERR.
REQ-014 SHALL accept a byte only on a rising edge with rx_valid=1 and rx_ready=1; rx_ready SHALL be 1 only in LEN_*, DATA_*, SUM_* states.
REQ-015 SHALL use the frame format: count N (16 bit), then N words, then checksum (16 bit); every 16-bit field is sent high byte first.
REQ-016 SHALL move IDLE/RUN/ERR -> LEN_HI on load=1; load SHALL be ignored in LEN_*, DATA_*, SUM_* states.
REQ-017 SHALL, on acceptance in LEN_LO: go to ERR if N > 2**ADDR_W, go to SUM_HI if N = 0, else go to DATA_HI with write address 0 and running sum 0.
REQ-018 SHALL, on acceptance in DATA_LO, write {hi,lo} to mem[addr], add it to the running sum modulo 2**16, increment addr, and go to SUM_HI when addr+1 = N, else to DATA_HI.
REQ-019 SHALL, on acceptance in SUM_LO, go to RUN if the received checksum equals the running sum, else go to ERR.
REQ-020 SHALL leave memory locations at or above N unchanged by a download.
REQ-021 SHALL, in RUN, drive instruction = mem[pc[ADDR_W-1:0]] combinationally (zero-cycle read latency, so the hCPU can execute single-cycle); upper pc bits are ignored (address wrap-around).
REQ-022 SHALL drive instruction = 16'h0000 in every state other than RUN.
REQ-023 SHALL drive cpu_reset = 1 in every state except RUN, and 0 in RUN; done = 1 only in RUN; error = 1 only in ERR.
REQ-024 SHALL, for load=1 in RUN, assert cpu_reset starting from the next cycle and restart the download; the CPU is held reset for the whole transfer.
REQ-025 SHALL tolerate any number of idle cycles (rx_valid=0) between bytes with no timeout.

Reset
REQ-026 SHALL, while reset_n=0 (asynchronously), force state IDLE, rx_ready=0, cpu_reset=1, done=0, error=0, instruction=0, addr=0, running sum=0.
REQ-027 SHALL NOT clear memory contents on reset.
REQ-028 SHALL abort any download in progress on reset_n=0, with no further memory writes.

Verification
REQ-029 SHALL verify: release reset, pulse load, send bytes 00 02 EC 10 E3 08 CF 18 -> RUN, done=1, cpu_reset=0, pc=0 gives 16'hEC10, pc=1 gives 16'hE308.
REQ-030 SHALL verify: same frame with checksum 00 00 -> ERR, error=1, cpu_reset=1, instruction=0; a later load plus a correct frame -> RUN.
REQ-031 SHALL verify: count bytes 80 01 (N=32769, ADDR_W=15) -> ERR immediately after the second byte, with no memory writes.
REQ-032 SHALL verify: frame 00 00 00 00 -> RUN; previous contents are still readable at pc=0.
REQ-033 SHALL verify: valid frame with 3 idle cycles between bytes, and load pulsed mid-frame -> identical result to REQ-029; rx_ready=0 in IDLE/RUN/ERR.
REQ-034 SHALL verify: reset_n=0 asserted between DATA_HI and DATA_LO -> outputs match REQ-026 immediately, and mem[0] is not modified.
